alu_pipeline_n: RTL and testbench
=================================

# alu_pipeline_n

Parametrised integer-result pipeline between the issuer and commit. It carries a result produced at issue through `NumStages` registered stages to a valid/ready commit port. Every stage forwards its result to the issuer. Forwarding is cancelled per stage by external WAW events and by younger in-pipe writers to the same `rd`. It generalises the fixed EX2/WB ALU pipeline to any depth from 1 to 4, with a configurable count of WAW ports and internal WAW tracking.

## Interface
Parameters:
- `DataW`, 32: result width; 65 for a capability-carrying build.
- `NumStages`, 2: pipeline register stages, 1..4; stage 0 is the entry stage and stage `NumStages-1` drives commit.
- `NumWawPorts`, 2: number of external WAW cancel ports, 1..4.

Ports:
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `flush_i`  in  1  synchronous kill of all stages.
- `us_valid_i`  in  1  issuer presents an instruction.
- `us_rdy_o`  out  1  pipeline accepts this cycle (combinational).
- `us_rf_we_i`  in  1  instruction writes `rd`.
- `us_rd_i`  in  5  destination register.
- `us_pc_i`  in  32  PC, carried to commit.
- `us_data_i`  in  DataW  result, computed combinationally upstream.
- `waw_valid_i`  in  NumWawPorts  external WAW event per port.
- `waw_rd_i`  in  5*NumWawPorts  `rd` per port; port p is bits [5p+4:5p].
- `fwd_act_o`  out  32  registered one-hot-or map of registers with a live forward; bit 0 is always 0.
- `fwd_valid_o`  out  NumStages  per-stage forward valid (registered).
- `fwd_addr_o`  out  5*NumStages  per-stage `rd`.
- `fwd_data_o`  out  DataW*NumStages  per-stage result.
- `ds_rdy_i`  in  1  commit accepts.
- `ds_valid_o`  out  1  last stage valid.
- `ds_we_o`, `ds_waddr_o` (5), `ds_wdata_o` (DataW), `ds_pc_o` (32)  out  last-stage fields.
- `ds_wrsv_o`  out  1  `ds_we_o` AND last-stage forward still valid.
- `occupancy_o`  out  3  number of valid stages.

## Operation
- Each stage k holds `v[k]`, `we`, `rd`, `pc`, `data` and `fok[k]` (forward-ok).
- Ready chain:
  - `rdy[N-1] = ~v[N-1] | ds_rdy_i`.
  - `rdy[k] = ~v[k] | rdy[k+1]`.
  - `us_rdy_o = rdy[0]`.
  - Bubbles collapse; a stage advances only when its own `rdy` is high.
- Accept: when `us_valid_i & us_rdy_o & ~flush_i`, stage 0 loads the `us_*` fields. `fok` is set to `us_rf_we_i & (us_rd_i != 0)`.
- Advance: stage k+1 loads stage k, including `fok`, when `rdy[k+1]`. Stage k clears `v` when it moves and receives nothing.
- External WAW: if any port p has `waw_valid_i[p]` and `waw_rd_i[p] == rd[k]`, then `fok[k]` is cleared this edge. This applies whether the stage stalls or advances; the cleared value travels with the entry.
- Internal WAW: on accept with `us_rf_we_i` and `us_rd_i != 0`, every valid older stage whose `rd` equals `us_rd_i` clears `fok`, so the younger writer owns the forward.
- `fwd_valid_o[k] = v[k] & fok[k]`.
- `fwd_act_o[i]` (i ≥ 1) is registered from the next-state values: 1 iff some stage's next `v & fok` is set with next `rd == i`. This keeps the issuer compare off the critical path.
- Flush clears all `v`, `fok` and `fwd_act_o` at the edge. An accept in the same cycle is dropped, and `us_rdy_o` is not gated by flush.
- `rd == 0` never forwards, even with `we` set.
- `occupancy_o` is the popcount of `v`, at most 4.

## Timing
- Reset values: all `v`, `fok` and `fwd_act_o` are 0; `ds_valid_o`, `ds_we_o` and `ds_wrsv_o` are 0; all data, pc and addr outputs are 0; `occupancy_o = 0`; `us_rdy_o = 1`.
- Latency: accepted at edge t, the instruction is on `ds_*` from t+`NumStages`-1 with no stall. With `NumStages=1` it is valid the cycle after accept.
- Throughput: 1 per cycle with `ds_rdy_i` held high.
- Full: all stages valid and `ds_rdy_i=0` gives `us_rdy_o=0` the same cycle. A `ds_rdy_i` rise re-opens `us_rdy_o` combinationally in that cycle.
- `fwd_valid_o` and `fwd_data_o` are valid for stage k on the cycle its register holds the entry. `fwd_act_o` matches `fwd_valid_o`/`fwd_addr_o` in that same cycle.
- Simultaneous events:
  - A WAW event on a stage that is moving clears `fok` at the destination.
  - Flush beats accept, advance and WAW.
  - Internal and external WAW on the same cycle OR together.
- Reset asserted mid-operation clears all state asynchronously; no output glitches to a stale valid after release.

## Test plan
- Reset and steady stream, `NumStages=3`: 4 back-to-back writes to rd=5,6,7,8 with data 0x11..0x44 and `ds_rdy_i=1`. Each appears on `ds_*` 2 cycles after accept, in order, with `ds_wrsv_o=1`, and `fwd_act_o` shows bits 5..8 while they are in flight.
- Backpressure: fill 3 stages, hold `ds_rdy_i=0` 5 cycles. `us_rdy_o=0`, `occupancy_o=3`, outputs stable; release and the 3 entries drain over 3 cycles.
- External WAW on stalled stage: rd=9 stalled in last stage; `waw_valid_i[1]=1`, `waw_rd_i` port1=9. `fwd_valid_o` of that stage drops next cycle, `fwd_act_o[9]=0`, and commit shows `ds_we_o=1`, `ds_wrsv_o=0`.
- Internal WAW: accept rd=3 data 0xA, then rd=3 data 0xB. The older entry's forward drops, `fwd_act_o[3]` stays 1 via the younger, and only the 0xB stage shows `fwd_valid_o`.
- Flush with concurrent accept: 2 stages valid, `flush_i=1` with `us_valid_i=1`. Next cycle `occupancy_o=0`, `fwd_act_o=0`, and no commit of any of the 3 instructions.
- rd=0 write and async reset mid-stream: the rd=0 entry commits with `ds_wrsv_o=0` and never sets `fwd_act_o`. `rst_i` pulsed mid-stream clears `ds_valid_o` immediately.

Source files
------------

// File: rtl/alu_pipeline_n_if.sv
// Issue/commit/forward bundle for alu_pipeline_n.
// master = issuer/commit side, slave = the pipeline.
interface alu_pipeline_n_if #(
   parameter int DataW       = 32,
   parameter int NumStages   = 2,
   parameter int NumWawPorts = 2
);
   logic                          flush_i;
   logic                          us_valid_i;
   logic                          us_rdy_o;
   logic                          us_rf_we_i;
   logic [4:0]                    us_rd_i;
   logic [31:0]                   us_pc_i;
   logic [DataW-1:0]              us_data_i;
   logic [NumWawPorts-1:0]        waw_valid_i;
   logic [5*NumWawPorts-1:0]      waw_rd_i;
   logic [31:0]                   fwd_act_o;
   logic [NumStages-1:0]          fwd_valid_o;
   logic [5*NumStages-1:0]        fwd_addr_o;
   logic [DataW*NumStages-1:0]    fwd_data_o;
   logic                          ds_rdy_i;
   logic                          ds_valid_o;
   logic                          ds_we_o;
   logic [4:0]                    ds_waddr_o;
   logic [DataW-1:0]              ds_wdata_o;
   logic [31:0]                   ds_pc_o;
   logic                          ds_wrsv_o;
   logic [2:0]                    occupancy_o;

   modport master (
      output flush_i, us_valid_i, us_rf_we_i, us_rd_i, us_pc_i, us_data_i,
             waw_valid_i, waw_rd_i, ds_rdy_i,
      input  us_rdy_o, fwd_act_o, fwd_valid_o, fwd_addr_o, fwd_data_o,
             ds_valid_o, ds_we_o, ds_waddr_o, ds_wdata_o, ds_pc_o, ds_wrsv_o,
             occupancy_o
   );

   modport slave (
      input  flush_i, us_valid_i, us_rf_we_i, us_rd_i, us_pc_i, us_data_i,
             waw_valid_i, waw_rd_i, ds_rdy_i,
      output us_rdy_o, fwd_act_o, fwd_valid_o, fwd_addr_o, fwd_data_o,
             ds_valid_o, ds_we_o, ds_waddr_o, ds_wdata_o, ds_pc_o, ds_wrsv_o,
             occupancy_o
   );
endinterface

// File: rtl/alu_pipeline_n.sv
// N-stage result pipeline from issue to commit with per-stage forwarding,
// collapsing bubbles, and forward cancellation on external/internal WAW.
module alu_pipeline_n #(
   parameter int DataW       = 32,
   parameter int NumStages   = 2,
   parameter int NumWawPorts = 2
) (
   input logic             clk_i,
   input logic             rst_i,
   alu_pipeline_n_if.slave bus
);
   localparam int N = NumStages;

   logic [N-1:0]                  r_v, r_fok, r_we;
   logic [N-1:0][4:0]             r_rd;
   logic [N-1:0][31:0]            r_pc;
   logic [N-1:0][DataW-1:0]       r_data;
   logic [31:0]                   r_act;

   logic [N-1:0]                  w_rdy, w_fok_c;
   logic [N-1:0]                  w_v_n, w_fok_n, w_we_n;
   logic [N-1:0][4:0]             w_rd_n;
   logic [N-1:0][31:0]            w_pc_n;
   logic [N-1:0][DataW-1:0]       w_data_n;
   logic [31:0]                   w_act_n;
   logic                          w_acc, w_iwaw, w_ext;
   logic [2:0]                    w_occ;

   always_comb begin
      w_rdy[N-1] = ~r_v[N-1] | bus.ds_rdy_i;
      for (int k = N-2; k >= 0; k--) w_rdy[k] = ~r_v[k] | w_rdy[k+1];
   end

   assign w_acc  = bus.us_valid_i & w_rdy[0] & ~bus.flush_i;
   assign w_iwaw = w_acc & bus.us_rf_we_i & (bus.us_rd_i != 5'd0);

   // Cancelled fok per current stage; it moves with the entry if the stage advances.
   always_comb begin
      w_fok_c = '0;
      w_ext   = 1'b0;
      for (int k = 0; k < N; k++) begin
         w_ext = 1'b0;
         for (int p = 0; p < NumWawPorts; p++)
            w_ext = w_ext | (bus.waw_valid_i[p] & (bus.waw_rd_i[5*p +: 5] == r_rd[k]));
         w_fok_c[k] = r_fok[k] & ~w_ext & ~(w_iwaw & r_v[k] & (r_rd[k] == bus.us_rd_i));
      end
   end

   always_comb begin
      w_v_n    = r_v;
      w_fok_n  = w_fok_c;
      w_we_n   = r_we;
      w_rd_n   = r_rd;
      w_pc_n   = r_pc;
      w_data_n = r_data;
      if (w_rdy[0]) begin
         w_v_n[0]   = w_acc;
         w_fok_n[0] = bus.us_rf_we_i & (bus.us_rd_i != 5'd0);
         if (w_acc) begin
            w_we_n[0]   = bus.us_rf_we_i;
            w_rd_n[0]   = bus.us_rd_i;
            w_pc_n[0]   = bus.us_pc_i;
            w_data_n[0] = bus.us_data_i;
         end
      end
      for (int k = 1; k < N; k++) begin
         if (w_rdy[k]) begin
            w_v_n[k]   = r_v[k-1];
            w_fok_n[k] = w_fok_c[k-1];
            if (r_v[k-1]) begin
               w_we_n[k]   = r_we[k-1];
               w_rd_n[k]   = r_rd[k-1];
               w_pc_n[k]   = r_pc[k-1];
               w_data_n[k] = r_data[k-1];
            end
         end
      end
      if (bus.flush_i) begin
         w_v_n   = '0;
         w_fok_n = '0;
      end
   end

   // Registered from next state so the issuer's compare sees a flop, not this cone.
   always_comb begin
      w_act_n = '0;
      for (int i = 1; i < 32; i++)
         for (int k = 0; k < N; k++)
            if (w_v_n[k] & w_fok_n[k] & (w_rd_n[k] == 5'(i))) w_act_n[i] = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_v    <= '0;
         r_fok  <= '0;
         r_we   <= '0;
         r_rd   <= '0;
         r_pc   <= '0;
         r_data <= '0;
         r_act  <= '0;
      end else begin
         r_v    <= w_v_n;
         r_fok  <= w_fok_n;
         r_we   <= w_we_n;
         r_rd   <= w_rd_n;
         r_pc   <= w_pc_n;
         r_data <= w_data_n;
         r_act  <= w_act_n;
      end
   end

   always_comb begin
      w_occ = '0;
      for (int k = 0; k < N; k++) w_occ = w_occ + 3'(r_v[k]);
   end

   assign bus.us_rdy_o    = w_rdy[0];
   assign bus.fwd_act_o   = r_act;
   assign bus.fwd_valid_o = r_v & r_fok;
   assign bus.fwd_addr_o  = r_rd;
   assign bus.fwd_data_o  = r_data;
   assign bus.ds_valid_o  = r_v[N-1];
   assign bus.ds_we_o     = r_we[N-1];
   assign bus.ds_waddr_o  = r_rd[N-1];
   assign bus.ds_wdata_o  = r_data[N-1];
   assign bus.ds_pc_o     = r_pc[N-1];
   assign bus.ds_wrsv_o   = r_we[N-1] & r_v[N-1] & r_fok[N-1];
   assign bus.occupancy_o = w_occ;
endmodule

// File: tb/tb_alu_pipeline_n.sv
// Directed table-driven bench for alu_pipeline_n at 3 stages, 2 WAW ports.
module tb_alu_pipeline_n;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_pipeline_n_if #(.DataW(32), .NumStages(3), .NumWawPorts(2)) bus ();
   alu_pipeline_n #(.DataW(32), .NumStages(3), .NumWawPorts(2)) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus)
   );

   typedef struct {
      logic        v, we, dsr, fl;
      logic [4:0]  rd;
      logic [31:0] d;
      logic [1:0]  wv;
      logic [9:0]  wrd;
      logic        e_dsv, e_we, e_wrsv, e_usr;
      logic [4:0]  e_wa;
      logic [31:0] e_wd;
      logic [2:0]  e_occ, e_fv;
      logic [31:0] e_act;
   } vec_t;

   vec_t tbl[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic logic [31:0] b(input int n);
      logic [31:0] one;
      one = 32'h1;
      return one << n;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic v, we, input logic [4:0] rd, input logic [31:0] d,
                      input logic dsr, fl, input logic [1:0] wv, input logic [9:0] wrd,
                      input logic e_dsv, e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
                      input logic e_wrsv, input logic [2:0] e_occ, e_fv,
                      input logic [31:0] e_act, input logic e_usr);
      vec_t t;
      t.v = v; t.we = we; t.rd = rd; t.d = d; t.dsr = dsr; t.fl = fl; t.wv = wv; t.wrd = wrd;
      t.e_dsv = e_dsv; t.e_we = e_we; t.e_wa = e_wa; t.e_wd = e_wd; t.e_wrsv = e_wrsv;
      t.e_occ = e_occ; t.e_fv = e_fv; t.e_act = e_act; t.e_usr = e_usr;
      tbl.push_back(t);
   endtask

   task automatic drive(input logic v, we, input logic [4:0] rd, input logic [31:0] d,
                        input logic dsr, fl, input logic [1:0] wv, input logic [9:0] wrd);
      bus.us_valid_i  = v;
      bus.us_rf_we_i  = we;
      bus.us_rd_i     = rd;
      bus.us_data_i   = d;
      bus.us_pc_i     = d + 32'h8000_0000;
      bus.ds_rdy_i    = dsr;
      bus.flush_i     = fl;
      bus.waw_valid_i = wv;
      bus.waw_rd_i    = wrd;
   endtask

   initial begin
      drive(0, 0, 0, 0, 1, 0, 0, 0);
      repeat (2) step();

      // reset state, with reset still asserted
      chk("rst ds_valid", 32'(bus.ds_valid_o), 0);
      chk("rst ds_we",    32'(bus.ds_we_o), 0);
      chk("rst ds_wrsv",  32'(bus.ds_wrsv_o), 0);
      chk("rst occ",      32'(bus.occupancy_o), 0);
      chk("rst fwd_act",  bus.fwd_act_o, 0);
      chk("rst fwd_valid", 32'(bus.fwd_valid_o), 0);
      chk("rst us_rdy",   32'(bus.us_rdy_o), 1);
      chk("rst ds_wdata", bus.ds_wdata_o, 0);
      chk("rst ds_pc",    bus.ds_pc_o, 0);
      rst = 1'b0;

      // steady stream
      add(1,1,5,32'h11,1,0,0,0, 0,0,0,0,0, 1,3'b001, b(5), 1);
      add(1,1,6,32'h22,1,0,0,0, 0,0,0,0,0, 2,3'b011, b(5)|b(6), 1);
      add(1,1,7,32'h33,1,0,0,0, 1,1,5,32'h11,1, 3,3'b111, b(5)|b(6)|b(7), 1);
      add(1,1,8,32'h44,1,0,0,0, 1,1,6,32'h22,1, 3,3'b111, b(6)|b(7)|b(8), 1);
      add(0,0,0,0,1,0,0,0,      1,1,7,32'h33,1, 2,3'b110, b(7)|b(8), 1);
      add(0,0,0,0,1,0,0,0,      1,1,8,32'h44,1, 1,3'b100, b(8), 1);
      add(0,0,0,0,1,0,0,0,      0,0,0,0,0,      0,3'b000, 0, 1);
      // backpressure: fill, hold 5 cycles, drain
      add(1,1,10,32'hA0,0,0,0,0, 0,0,0,0,0, 1,3'b001, b(10), 1);
      add(1,1,11,32'hB0,0,0,0,0, 0,0,0,0,0, 2,3'b011, b(10)|b(11), 1);
      add(1,1,12,32'hC0,0,0,0,0, 1,1,10,32'hA0,1, 3,3'b111, b(10)|b(11)|b(12), 0);
      for (int i = 0; i < 5; i++)
         add(1,1,13,32'hD0,0,0,0,0, 1,1,10,32'hA0,1, 3,3'b111, b(10)|b(11)|b(12), 0);
      add(0,0,0,0,1,0,0,0, 1,1,11,32'hB0,1, 2,3'b110, b(11)|b(12), 1);
      add(0,0,0,0,1,0,0,0, 1,1,12,32'hC0,1, 1,3'b100, b(12), 1);
      add(0,0,0,0,1,0,0,0, 0,0,0,0,0,       0,3'b000, 0, 1);
      // external WAW on stalled last stage via port 1
      add(1,1,9,32'h99,0,0,0,0, 0,0,0,0,0,      1,3'b001, b(9), 1);
      add(0,0,0,0,0,0,0,0,      0,0,0,0,0,      1,3'b010, b(9), 1);
      add(0,0,0,0,0,0,0,0,      1,1,9,32'h99,1, 1,3'b100, b(9), 1);
      add(0,0,0,0,0,0,2'b10,{5'd9,5'd0}, 1,1,9,32'h99,0, 1,3'b000, 0, 1);
      add(0,0,0,0,1,0,0,0,      0,0,0,0,0,      0,3'b000, 0, 1);
      // internal WAW: younger rd=3 owns the forward
      add(1,1,3,32'hA,1,0,0,0, 0,0,0,0,0,     1,3'b001, b(3), 1);
      add(1,1,3,32'hB,1,0,0,0, 0,0,0,0,0,     2,3'b001, b(3), 1);
      add(0,0,0,0,1,0,0,0,     1,1,3,32'hA,0, 2,3'b010, b(3), 1);
      add(0,0,0,0,1,0,0,0,     1,1,3,32'hB,1, 1,3'b100, b(3), 1);
      add(0,0,0,0,1,0,0,0,     0,0,0,0,0,     0,3'b000, 0, 1);
      // flush with concurrent accept; nothing may commit afterwards
      add(1,1,20,32'h20,1,0,0,0, 0,0,0,0,0, 1,3'b001, b(20), 1);
      add(1,1,21,32'h21,1,0,0,0, 0,0,0,0,0, 2,3'b011, b(20)|b(21), 1);
      add(1,1,22,32'h22,1,1,0,0, 0,0,0,0,0, 0,3'b000, 0, 1);
      add(0,0,0,0,1,0,0,0,       0,0,0,0,0, 0,3'b000, 0, 1);
      add(0,0,0,0,1,0,0,0,       0,0,0,0,0, 0,3'b000, 0, 1);
      // rd=0 write never forwards
      add(1,1,0,32'h55,1,0,0,0, 0,0,0,0,0,      1,3'b000, 0, 1);
      add(0,0,0,0,1,0,0,0,      0,0,0,0,0,      1,3'b000, 0, 1);
      add(0,0,0,0,1,0,0,0,      1,1,0,32'h55,0, 1,3'b000, 0, 1);
      add(0,0,0,0,1,0,0,0,      0,0,0,0,0,      0,3'b000, 0, 1);

      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].we, tbl[i].rd, tbl[i].d, tbl[i].dsr, tbl[i].fl, tbl[i].wv, tbl[i].wrd);
         step();
         chk($sformatf("v%0d ds_valid", i), 32'(bus.ds_valid_o), 32'(tbl[i].e_dsv));
         chk($sformatf("v%0d us_rdy", i),   32'(bus.us_rdy_o), 32'(tbl[i].e_usr));
         chk($sformatf("v%0d occ", i),      32'(bus.occupancy_o), 32'(tbl[i].e_occ));
         chk($sformatf("v%0d fwd_act", i),  bus.fwd_act_o, tbl[i].e_act);
         chk($sformatf("v%0d fwd_valid", i), 32'(bus.fwd_valid_o), 32'(tbl[i].e_fv));
         chk($sformatf("v%0d ds_wrsv", i),  32'(bus.ds_wrsv_o), 32'(tbl[i].e_wrsv));
         if (tbl[i].e_dsv) begin
            chk($sformatf("v%0d ds_waddr", i), 32'(bus.ds_waddr_o), 32'(tbl[i].e_wa));
            chk($sformatf("v%0d ds_wdata", i), bus.ds_wdata_o, tbl[i].e_wd);
            chk($sformatf("v%0d ds_we", i),    32'(bus.ds_we_o), 32'(tbl[i].e_we));
            chk($sformatf("v%0d ds_pc", i),    bus.ds_pc_o, tbl[i].e_wd + 32'h8000_0000);
         end
      end

      // async reset mid-stream, between clock edges
      drive(1, 1, 1, 32'h1, 1, 0, 0, 0); step();
      drive(1, 1, 2, 32'h2, 1, 0, 0, 0); step();
      drive(1, 1, 3, 32'h3, 1, 0, 0, 0); step();
      chk("pre-rst ds_valid", 32'(bus.ds_valid_o), 1);
      chk("pre-rst ds_wdata", bus.ds_wdata_o, 32'h1);
      drive(0, 0, 0, 0, 1, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      chk("arst ds_valid", 32'(bus.ds_valid_o), 0);
      chk("arst occ",      32'(bus.occupancy_o), 0);
      chk("arst fwd_act",  bus.fwd_act_o, 0);
      chk("arst us_rdy",   32'(bus.us_rdy_o), 1);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("post-rst ds_valid", 32'(bus.ds_valid_o), 0);
      chk("post-rst occ",      32'(bus.occupancy_o), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
